// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use interlock, taken-branch
// flush from MEM, and a wait FSM for multi-cycle data-memory accesses.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 5,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             exmem_br_taken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic             freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err_q;

  logic mem_acc;
  logic load_use;
  logic freeze_c;
  logic branch_c;
  logic stall_c;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    mem_acc  = exmem_memread | exmem_memwrite;
    load_use = idex_memread && (idex_rd != 5'd0) &&
               ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    freeze_c = 1'b0;
    unique case (state)
      S_RUN:      freeze_c = mem_acc && !dmem_ready;
      S_MEM_WAIT: freeze_c = !dmem_ready;
      S_ERR:      freeze_c = 1'b1;
      default:    freeze_c = 1'b0;
    endcase
    // Freeze outranks a branch flush, which outranks the load-use interlock.
    branch_c = exmem_br_taken && !freeze_c;
    stall_c  = load_use && !branch_c && !freeze_c;
  end

  always_comb begin
    dmem_req    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    freeze      = 1'b0;
    mem_err     = 1'b0;
    if (reset) begin
      flush = 1'b1;
    end else begin
      dmem_req = mem_acc && (state != S_ERR);
      mem_err  = mem_err_q;
      if (freeze_c) begin
        freeze = 1'b1;
      end else if (branch_c) begin
        pc_src     = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        flush      = 1'b1;
      end else if (stall_c) begin
        idex_bubble = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (mem_acc && !dmem_ready) begin
            state    <= S_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT_V) begin
            state     <= S_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_ERR: begin
          // Only reset leaves ERR; the error flag stays set until then.
          mem_err_q <= 1'b1;
        end
        default: state <= S_RUN;
      endcase

      if ((freeze_c || stall_c) && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_c && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors are queued as each
// step is driven and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 3;

  // {dmem_req, pc_write, pc_src, ifid_write, idex_bubble, flush, freeze, mem_err}
  typedef logic [7:0] outs_t;
  localparam outs_t O_RST = 8'b0000_0100;
  localparam outs_t O_RUN = 8'b0101_0000;
  localparam outs_t O_LU  = 8'b0000_1000;
  localparam outs_t O_BR  = 8'b0111_0100;
  localparam outs_t O_FRZ = 8'b1000_0010;
  localparam outs_t O_GO  = 8'b1101_0000;
  localparam outs_t O_BRM = 8'b1111_0100;
  localparam outs_t O_ERR = 8'b0000_0011;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
  logic             idex_memread, exmem_memread, exmem_memwrite, exmem_br_taken, dmem_ready;
  logic             dmem_req, pc_write, pc_src, ifid_write, idex_bubble, flush, freeze, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  outs_t exp_q[$];
  string tag_q[$];
  outs_t obs_v;

  assign obs_v = {dmem_req, pc_write, pc_src, ifid_write, idex_bubble, flush, freeze, mem_err};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .WAIT_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .exmem_br_taken(exmem_br_taken),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_write(pc_write),
    .pc_src(pc_src), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush(flush), .freeze(freeze), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; queue the expectation, compare mid-cycle, then
  // advance past the next rising edge.
  task automatic step(input string tag, input outs_t exp);
    outs_t e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 32'(obs_v), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int s, input int f);
    check({tag, "_stall"}, 32'(stall_cnt), 32'(s));
    check({tag, "_flush"}, 32'(flush_cnt), 32'(f));
  endtask

  task automatic clear_inputs();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0; idex_memread = 1'b0;
    exmem_memread = 1'b0; exmem_memwrite = 1'b0; exmem_br_taken = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic load_use_rs2();
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();

    // Reset forces flush only; counters clear.
    step("reset_outs", O_RST);
    check_cnt("reset", 0, 0);
    reset = 1'b0;
    step("idle", O_RUN);
    check_cnt("idle", 0, 0);

    // T1 load-use on rs2, then on rs1.
    load_use_rs2();
    step("t1_lu_rs2", O_LU);
    check_cnt("t1", 1, 0);
    clear_inputs();
    idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7;
    step("t1_lu_rs1", O_LU);
    check_cnt("t1b", 2, 0);

    // T2 rd=x0 never interlocks; non-load never interlocks.
    clear_inputs();
    idex_memread = 1'b1;
    step("t2_rd_x0", O_RUN);
    clear_inputs();
    idex_rd = 5'd5; ifid_rs1 = 5'd5;
    step("t2_no_load", O_RUN);
    check_cnt("t2", 2, 0);

    // T3 branch beats load-use.
    clear_inputs();
    load_use_rs2();
    exmem_br_taken = 1'b1;
    step("t3_branch", O_BR);
    check_cnt("t3", 2, 1);

    // T4 load waits three cycles.
    clear_inputs();
    exmem_memread = 1'b1;
    for (int i = 0; i < 3; i++) step("t4_wait", O_FRZ);
    dmem_ready = 1'b1;
    step("t4_ready", O_GO);
    check_cnt("t4", 5, 1);
    exmem_memread = 1'b0;
    step("t4_back_run", O_RUN);
    exmem_memwrite = 1'b1;
    step("t4_store_ready", O_GO);

    // Branch sharing the slot with a store: flush deferred to the ready cycle.
    clear_inputs();
    exmem_memwrite = 1'b1; exmem_br_taken = 1'b1;
    step("brmem_wait", O_FRZ);
    dmem_ready = 1'b1;
    step("brmem_ready", O_BRM);
    check_cnt("brmem", 6, 2);

    // T6 saturation after a fresh reset.
    clear_inputs();
    reset = 1'b1;
    step("sat_reset", O_RST);
    reset = 1'b0;
    load_use_rs2();
    for (int i = 0; i < 10; i++) begin
      step("sat_lu", O_LU);
      check("sat_stall", 32'(stall_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end

    // T5 timeout: five frozen cycles, then sticky ERR.
    clear_inputs();
    reset = 1'b1;
    step("t5_reset", O_RST);
    reset = 1'b0;
    exmem_memread = 1'b1;
    for (int i = 0; i < 5; i++) step("t5_wait", O_FRZ);
    step("t5_err", O_ERR);
    step("t5_err_hold", O_ERR);
    dmem_ready = 1'b1;
    step("t5_err_sticky", O_ERR);
    check_cnt("t5", 7, 0);
    reset = 1'b1;
    step("t5_reset_err", O_RST);
    reset = 1'b0;
    clear_inputs();
    step("t5_after_reset", O_RUN);
    check_cnt("t5_cleared", 0, 0);

    // Reset in the middle of MEM_WAIT leaves no residual freeze.
    exmem_memread = 1'b1;
    step("mw_enter", O_FRZ);
    step("mw_hold", O_FRZ);
    reset = 1'b1;
    step("mw_reset", O_RST);
    reset = 1'b0;
    exmem_memread = 1'b0;
    step("mw_after_reset", O_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
